// File: rtl/board_pixel_gen.sv
// Board-state RAM plus pixel renderer for the VGA controller: wood, grid, stones, cursor.
// Optional feature macro: CURSOR_BLINK_EN (cursor blinks every 2^BLINK_LOG2 frames).
module board_pixel_gen #(
  parameter int CELL_LOG2  = 5,
  parameter int BOARD_N    = 15,
  parameter int X_ORG      = 80,
  parameter int STONE_R2   = 144,
  parameter int BLINK_LOG2 = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [8:0]  row_addr,
  input  logic [9:0]  col_addr,
  output logic [11:0] pixel_data,
  input  logic        wr_en,
  input  logic [3:0]  wr_x,
  input  logic [3:0]  wr_y,
  input  logic [1:0]  wr_data,
  input  logic        clr_req,
  output logic        busy,
  input  logic [3:0]  cur_x,
  input  logic [3:0]  cur_y,
  input  logic        frame_tick
);

  localparam int CELLS    = BOARD_N * BOARD_N;
  localparam int ADDR_W   = $clog2(CELLS);
  localparam int BOARD_PX = BOARD_N << CELL_LOG2;
  localparam int D2_W     = 2 * CELL_LOG2;

  typedef logic [ADDR_W-1:0]           addr_t;
  typedef logic [CELL_LOG2-1:0]        ofs_t;
  typedef logic signed [CELL_LOG2:0]   sofs_t;
  typedef logic signed [D2_W:0]        sq_t;
  typedef logic [D2_W-1:0]             d2_t;
  typedef logic [BLINK_LOG2-1:0]       blink_cnt_t;

  typedef enum logic [1:0] {
    CODE_EMPTY = 2'd0,
    CODE_BLACK = 2'd1,
    CODE_WHITE = 2'd2,
    CODE_RSVD  = 2'd3
  } cell_code_e;

  typedef enum logic {ST_CLEAR, ST_IDLE} clr_state_e;

  localparam addr_t      LAST_ADDR = addr_t'(CELLS - 1);
  localparam logic [8:0] ROW_END   = 9'(BOARD_PX);
  localparam logic [9:0] COL_ORG   = 10'(X_ORG);
  localparam logic [9:0] COL_END   = 10'(X_ORG + BOARD_PX);
  localparam logic [3:0] LAST_CELL = 4'(BOARD_N - 1);
  localparam ofs_t       HALF      = ofs_t'(1 << (CELL_LOG2 - 1));
  localparam d2_t        STONE_LIM = d2_t'(STONE_R2);

  localparam logic [11:0] RGB_NONE   = 12'h000;
  localparam logic [11:0] RGB_CURSOR = 12'hF00;
  localparam logic [11:0] RGB_BLACK  = 12'h111;
  localparam logic [11:0] RGB_WHITE  = 12'hFFF;
  localparam logic [11:0] RGB_GRID   = 12'h000;
  localparam logic [11:0] RGB_WOOD   = 12'hDA6;

  // ---------------------------------------------------------------- clear sweep / write port
  clr_state_e state, state_nx;
  addr_t      clr_addr, clr_addr_nx;
  logic       mem_we;
  addr_t      mem_wa;
  cell_code_e mem_wd;
  logic       wr_ok;
  addr_t      wr_cell_addr;

  assign wr_ok        = wr_en && (wr_x <= LAST_CELL) && (wr_y <= LAST_CELL);
  assign wr_cell_addr = addr_t'(wr_y * BOARD_N + wr_x);
  assign busy         = (state == ST_CLEAR);

  // NOTE: flops are assigned with <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_CLEAR;
      clr_addr <= '0;
    end else begin
      state    <= state_nx;
      clr_addr <= clr_addr_nx;
    end
  end

  always_comb begin
    // NOTE: every output gets a default up front, so no branch can infer a latch.
    state_nx    = state;
    clr_addr_nx = clr_addr;
    mem_we      = 1'b0;
    mem_wa      = wr_cell_addr;
    mem_wd      = cell_code_e'(wr_data);
    case (state)
      ST_CLEAR: begin
        mem_we = 1'b1;
        mem_wa = clr_addr;
        mem_wd = CODE_EMPTY;
        if (clr_addr == LAST_ADDR) begin
          state_nx    = ST_IDLE;
          clr_addr_nx = '0;
        end else begin
          clr_addr_nx = clr_addr + addr_t'(1);
        end
      end
      ST_IDLE: begin
        if (clr_req) state_nx = ST_CLEAR;
        else         mem_we   = wr_ok;
      end
    endcase
  end

  // ---------------------------------------------------------------- cursor blink
  logic blink_on;

`ifdef CURSOR_BLINK_EN
  blink_cnt_t frame_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (frame_tick) begin
      frame_cnt <= frame_cnt + blink_cnt_t'(1);
      if (&frame_cnt) blink_on <= ~blink_on;
    end
  end
`else
  logic unused_frame_tick;
  assign unused_frame_tick = frame_tick;
  assign blink_on          = 1'b1;
`endif

  // ---------------------------------------------------------------- stage 1: decode + RAM read
  logic [9:0] col_rel;
  logic       in_board_c;
  logic [3:0] cx_c, cy_c;
  ofs_t       ox_c, oy_c;
  sofs_t      dx_c, dy_c;
  sq_t        dx_w, dy_w;
  d2_t        d2_c;
  addr_t      rd_addr;
  logic       rim_c, cursor_c, grid_c;

  assign col_rel    = col_addr - COL_ORG;
  assign in_board_c = (row_addr < ROW_END) && (col_addr >= COL_ORG) && (col_addr < COL_END);
  assign cx_c       = 4'(col_rel >> CELL_LOG2);
  assign cy_c       = 4'(row_addr >> CELL_LOG2);
  assign ox_c       = ofs_t'(col_rel);
  assign oy_c       = ofs_t'(row_addr);
  assign dx_c       = sofs_t'({1'b0, ox_c}) - sofs_t'(HALF);
  assign dy_c       = sofs_t'({1'b0, oy_c}) - sofs_t'(HALF);
  assign dx_w       = sq_t'(dx_c);
  assign dy_w       = sq_t'(dy_c);
  assign d2_c       = d2_t'(dx_w * dx_w + dy_w * dy_w);
  assign rd_addr    = in_board_c ? addr_t'(cy_c * BOARD_N + cx_c) : '0;

  // Cursor frame is the outer two pixels of the cell on every side.
  assign rim_c    = (ox_c[CELL_LOG2-1:1] == '0) || (&ox_c[CELL_LOG2-1:1]) ||
                    (oy_c[CELL_LOG2-1:1] == '0) || (&oy_c[CELL_LOG2-1:1]);
  assign cursor_c = rim_c && (cx_c == cur_x) && (cy_c == cur_y) && blink_on;
  assign grid_c   = (ox_c == HALF) || (oy_c == HALF);

  logic       in_board_q, cursor_q, stone_q, grid_q, empty_q;
  cell_code_e rd_code_q;
  cell_code_e board_mem [CELLS];

  always_ff @(posedge clk) begin
    if (rst) begin
      in_board_q <= 1'b0;
      cursor_q   <= 1'b0;
      stone_q    <= 1'b0;
      grid_q     <= 1'b0;
      empty_q    <= 1'b1;
    end else begin
      in_board_q <= in_board_c;
      cursor_q   <= cursor_c;
      stone_q    <= (d2_c <= STONE_LIM);
      grid_q     <= grid_c;
      empty_q    <= busy;
    end
  end

  // NOTE: the board RAM has no reset; its contents are zeroed by the clear sweep instead.
  // The read samples the old word, so a same-cycle write to that cell is seen next read.
  always_ff @(posedge clk) begin
    rd_code_q <= board_mem[rd_addr];
    if (mem_we) board_mem[mem_wa] <= mem_wd;
  end

  // ---------------------------------------------------------------- stage 2: colour select
  cell_code_e  code_s;
  logic [11:0] pixel_nx;

  always_comb begin
    code_s   = empty_q ? CODE_EMPTY : rd_code_q;
    pixel_nx = RGB_WOOD;
    if (!in_board_q)                          pixel_nx = RGB_NONE;
    else if (cursor_q)                        pixel_nx = RGB_CURSOR;
    else if (stone_q && code_s == CODE_BLACK) pixel_nx = RGB_BLACK;
    else if (stone_q && code_s == CODE_WHITE) pixel_nx = RGB_WHITE;
    else if (grid_q)                          pixel_nx = RGB_GRID;
  end

  always_ff @(posedge clk) begin
    if (rst) pixel_data <= RGB_NONE;
    else     pixel_data <= pixel_nx;
  end

endmodule

// File: tb/tb_board_pixel_gen.sv
// Self-checking bench for board_pixel_gen: behavioural board/pixel model compared every cycle,
// plus directed literal checks; randomized traffic at the end.
module tb_board_pixel_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [8:0]  row_addr;
  logic [9:0]  col_addr;
  logic [11:0] pixel_data;
  logic        wr_en;
  logic [3:0]  wr_x, wr_y;
  logic [1:0]  wr_data;
  logic        clr_req;
  logic        busy;
  logic [3:0]  cur_x, cur_y;
  logic        frame_tick;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  board_pixel_gen dut (
    .clk        (clk),
    .rst        (rst),
    .row_addr   (row_addr),
    .col_addr   (col_addr),
    .pixel_data (pixel_data),
    .wr_en      (wr_en),
    .wr_x       (wr_x),
    .wr_y       (wr_y),
    .wr_data    (wr_data),
    .clr_req    (clr_req),
    .busy       (busy),
    .cur_x      (cur_x),
    .cur_y      (cur_y),
    .frame_tick (frame_tick)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- reference model
  int          board [225];
  int          busy_left;
  int          ticks;
  logic [11:0] pend_pix;
  logic [11:0] exp_pix;
  bit          model_live = 1'b0;

  function automatic bit ref_blink_on();
`ifdef CURSOR_BLINK_EN
    return ((ticks / 16) % 2) == 0;
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [11:0] ref_pixel(input int row, input int col, input bit empty,
                                            input bit blink, input int cxc, input int cyc);
    int cx, cy, ox, oy, dx, dy, code;
    if (row >= 480 || col < 80 || col >= 560) return 12'h000;
    cx = (col - 80) / 32;
    cy = row / 32;
    ox = (col - 80) % 32;
    oy = row % 32;
    if (cx == cxc && cy == cyc && blink && (ox < 2 || ox > 29 || oy < 2 || oy > 29))
      return 12'hF00;
    code = empty ? 0 : board[cy * 15 + cx];
    dx = ox - 16;
    dy = oy - 16;
    if (dx * dx + dy * dy <= 144) begin
      if (code == 1) return 12'h111;
      if (code == 2) return 12'hFFF;
    end
    if (ox == 16 || oy == 16) return 12'h000;
    return 12'hDA6;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      exp_pix   = 12'h000;
      pend_pix  = 12'h000;
      busy_left = 225;
      ticks     = 0;
      foreach (board[i]) board[i] = 0;
    end else begin
      exp_pix  = pend_pix;
      pend_pix = ref_pixel(int'(row_addr), int'(col_addr), busy_left > 0, ref_blink_on(),
                           int'(cur_x), int'(cur_y));
      if (busy_left > 0) busy_left--;
      else if (clr_req) begin
        busy_left = 225;
        foreach (board[i]) board[i] = 0;
      end else if (wr_en && wr_x < 15 && wr_y < 15)
        board[int'(wr_y) * 15 + int'(wr_x)] = int'(wr_data);
      if (frame_tick) ticks++;
    end
    model_live = 1'b1;
  end

  always @(negedge clk) begin
    if (model_live) begin
      check("model_pixel", pixel_data, exp_pix);
      check("model_busy", busy, busy_left > 0);
    end
  end

  // ---------------------------------------------------------------- directed helpers
  task automatic present(input int r, input int c);
    row_addr = 9'(r);
    col_addr = 10'(c);
    repeat (2) @(negedge clk);
  endtask

  task automatic write_cell(input int x, input int y, input int d);
    wr_x    = 4'(x);
    wr_y    = 4'(y);
    wr_data = 2'(d);
    wr_en   = 1'b1;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  // Counts cycles with busy high, starting at the current negedge; bounded.
  task automatic wait_idle(output int n);
    n = 0;
    for (int i = 0; i < 2000 && busy; i++) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------------------------------------------------------- stimulus
  initial begin
    int n;
    rst = 1'b1; row_addr = '0; col_addr = '0; wr_en = 1'b0; wr_x = '0; wr_y = '0;
    wr_data = '0; clr_req = 1'b0; cur_x = '0; cur_y = '0; frame_tick = 1'b0;

    repeat (3) @(negedge clk);
    check("reset_pixel", pixel_data, 12'h000);
    check("reset_busy", busy, 1'b1);
    rst = 1'b0;
    wait_idle(n);
    check("init_clear_len", n, 225);

    present(240, 320);
    check("grid_centre_empty", pixel_data, 12'h000);
    present(234, 314);
    check("wood_empty_cell", pixel_data, 12'hDA6);

    cur_x = 4'd0; cur_y = 4'd0;
    write_cell(7, 7, 1);
    present(240, 320);
    check("black_stone", pixel_data, 12'h111);
    write_cell(7, 7, 2);
    present(240, 320);
    check("white_stone", pixel_data, 12'hFFF);

    cur_x = 4'd3; cur_y = 4'd3;
    present(5, 85);
    check("wood_cell00", pixel_data, 12'hDA6);
    present(5, 40);
    check("left_of_board", pixel_data, 12'h000);
    present(5, 600);
    check("right_of_board", pixel_data, 12'h000);

    cur_x = 4'd0; cur_y = 4'd0;
    present(0, 80);
    check("cursor_on", pixel_data, 12'hF00);
    for (int i = 0; i < 16; i++) begin
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      @(negedge clk);
    end
    present(0, 80);
`ifdef CURSOR_BLINK_EN
    check("cursor_blink_off", pixel_data, 12'hDA6);
`else
    check("cursor_always_on", pixel_data, 12'hF00);
`endif

    write_cell(15, 7, 1);
    present(266, 90);
    check("wr_x15_ignored", pixel_data, 12'hDA6);

    write_cell(5, 5, 1);
    present(170, 250);
    check("stone_55", pixel_data, 12'h111);
    wr_x = 4'd5; wr_y = 4'd5; wr_data = 2'd2; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    @(negedge clk);
    check("read_first_old", pixel_data, 12'h111);
    @(negedge clk);
    check("read_first_new", pixel_data, 12'hFFF);

    write_cell(7, 7, 1);
    present(234, 314);
    check("stone_before_clear", pixel_data, 12'h111);
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    n = 0;
    for (int i = 0; i < 2000 && busy; i++) begin
      n++;
      if (n == 20) begin
        wr_x = 4'd2; wr_y = 4'd2; wr_data = 2'd1; wr_en = 1'b1;
      end else wr_en = 1'b0;
      if (n == 50) check("blank_during_sweep", pixel_data, 12'hDA6);
      @(negedge clk);
    end
    wr_en = 1'b0;
    check("clear_len", n, 225);
    present(234, 314);
    check("cleared_77", pixel_data, 12'hDA6);
    present(74, 154);
    check("busy_write_ignored", pixel_data, 12'hDA6);

    write_cell(3, 3, 2);
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    n = 0;
    for (int i = 0; i < 2000 && busy; i++) begin
      n++;
      clr_req = (n == 100);
      @(negedge clk);
    end
    clr_req = 1'b0;
    check("clear_len_second_req", n, 225);

    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    repeat (60) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_idle(n);
    check("clear_len_after_rst", n, 225);

    for (int i = 0; i < 4000; i++) begin
      row_addr   = 9'($urandom_range(0, 500));
      col_addr   = 10'($urandom_range(0, 639));
      wr_en      = ($urandom_range(0, 2) == 0);
      wr_x       = 4'($urandom_range(0, 15));
      wr_y       = 4'($urandom_range(0, 15));
      wr_data    = 2'($urandom_range(0, 3));
      frame_tick = ($urandom_range(0, 7) == 0);
      clr_req    = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 31) == 0) begin
        cur_x = 4'($urandom_range(0, 15));
        cur_y = 4'($urandom_range(0, 15));
      end
      @(negedge clk);
    end
    wr_en = 1'b0; frame_tick = 1'b0; clr_req = 1'b0;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
